// File: rtl/bp_be_pkg.sv
// Shared BE accelerator types: decode enums plus the tile sequencer state and descriptor.
package bp_be_pkg;

  localparam int bp_be_acc_paddr_width_gp = 40;
  localparam int bp_be_acc_len_width_gp   = 16;

  typedef enum logic [1:0] {
    e_acc_op_none,
    e_acc_op_tile,
    e_acc_op_csr_rd,
    e_acc_op_csr_wr
  } bp_be_acc_op_e;

  typedef struct packed {
    logic          v;
    bp_be_acc_op_e op;
    logic [4:0]    rd_addr;
  } bp_be_acc_decode_s;

  typedef enum logic [1:0] {
    e_acc_seq_idle,
    e_acc_seq_dest,
    e_acc_seq_act,
    e_acc_seq_wt
  } bp_be_acc_seq_state_e;

  typedef struct packed {
    logic [bp_be_acc_paddr_width_gp-1:0] act_base;
    logic [bp_be_acc_paddr_width_gp-1:0] wt_base;
    logic [bp_be_acc_paddr_width_gp-1:0] dest;
    logic [bp_be_acc_len_width_gp-1:0]   len;
  } bp_be_acc_desc_s;

endpackage

// File: rtl/bp_be_acc_credit_counter.sv
// Outstanding-writeback counter: saturating up/down, flags a decrement attempted at zero.
module bp_be_acc_credit_counter #(
  parameter int max_p   = 2,
  parameter int width_p = $clog2(max_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [width_p-1:0] count_next_o,
  output logic               underflow_o
);

  logic [width_p-1:0] count_q, count_d;

  // A decrement at zero is dropped; simultaneous inc and valid dec cancel.
  always_comb begin
    underflow_o = dec_i & (count_q == '0);
    count_d     = count_q;
    case ({inc_i, dec_i & ~underflow_o})
      2'b10: if (count_q != width_p'(max_p)) count_d = count_q + width_p'(1);
      2'b01: count_d = count_q - width_p'(1);
      default: count_d = count_q;
    endcase
  end

  assign count_next_o = count_d;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= '0;
    else            count_q <= count_d;
  end

endmodule

// File: rtl/bp_be_acc_tile_sequencer.sv
// Per-tile sequencer: one destination token, then alternating act/wt block loads,
// gated by writeback credits. Every output is a flop fed from next-state decode.
module bp_be_acc_tile_sequencer
  import bp_be_pkg::*;
#(
  parameter int paddr_width_p = bp_be_acc_paddr_width_gp,
  parameter int len_width_p   = bp_be_acc_len_width_gp,
  parameter int block_bytes_p = 64,
  parameter int credits_p     = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     cfg_v_i,
  output logic                     cfg_ready_o,
  input  logic [paddr_width_p-1:0] cfg_act_base_i,
  input  logic [paddr_width_p-1:0] cfg_wt_base_i,
  input  logic [paddr_width_p-1:0] cfg_dest_i,
  input  logic [len_width_p-1:0]   cfg_len_i,
  output logic                     dest_v_o,
  output logic [paddr_width_p-1:0] dest_addr_o,
  input  logic                     dest_ready_i,
  output logic                     cmd_v_o,
  output logic [paddr_width_p-1:0] cmd_addr_o,
  output logic                     cmd_act_not_wt_o,
  output logic                     cmd_last_o,
  input  logic                     cmd_ready_i,
  input  logic                     wb_ack_i,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     busy_o
);

  localparam int cnt_width_lp = $clog2(credits_p + 1);
  localparam int blk_shift_lp = $clog2(block_bytes_p);

  // Handshake: a transfer happens on a rising edge where valid & ready; a raised
  // valid and its payload hold until that transfer.
  bp_be_acc_seq_state_e state_q, state_d;
  bp_be_acc_desc_s      desc_q, desc_d;
  logic [len_width_p-1:0]   idx_q, idx_d, len_d;
  logic                     cfg_ready_q, cfg_ready_d;
  logic                     dest_v_q, dest_v_d;
  logic [paddr_width_p-1:0] dest_addr_q, dest_addr_d;
  logic                     cmd_v_q, cmd_v_d;
  logic [paddr_width_p-1:0] cmd_addr_q, cmd_addr_d, base_d;
  logic                     cmd_act_q, cmd_act_d;
  logic                     cmd_last_q, cmd_last_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     busy_q, busy_d;
  logic                     cfg_fire, dest_fire, cmd_fire, zero_len, ack_underflow;
  logic [cnt_width_lp-1:0]  credit_cnt_next;

  assign cfg_fire  = cfg_v_i & cfg_ready_q;
  assign dest_fire = dest_v_q & dest_ready_i;
  assign cmd_fire  = cmd_v_q & cmd_ready_i;

  bp_be_acc_credit_counter #(
    .max_p   (credits_p),
    .width_p (cnt_width_lp)
  ) credit_cnt (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .inc_i        (dest_fire),
    .dec_i        (wb_ack_i),
    .count_next_o (credit_cnt_next),
    .underflow_o  (ack_underflow)
  );

  always_comb begin
    state_d  = state_q;
    desc_d   = desc_q;
    idx_d    = idx_q;
    zero_len = 1'b0;
    case (state_q)
      e_acc_seq_idle: begin
        if (cfg_fire) begin
          desc_d.act_base = bp_be_acc_paddr_width_gp'(cfg_act_base_i);
          desc_d.wt_base  = bp_be_acc_paddr_width_gp'(cfg_wt_base_i);
          desc_d.dest     = bp_be_acc_paddr_width_gp'(cfg_dest_i);
          desc_d.len      = bp_be_acc_len_width_gp'(cfg_len_i);
          idx_d           = '0;
          if (cfg_len_i == '0) zero_len = 1'b1;
          else                 state_d  = e_acc_seq_dest;
        end
      end
      e_acc_seq_dest: if (dest_fire) state_d = e_acc_seq_act;
      e_acc_seq_act:  if (cmd_fire)  state_d = e_acc_seq_wt;
      e_acc_seq_wt: begin
        if (cmd_fire) begin
          // cmd_last_q already encodes idx == K-1 for the pair in flight.
          if (cmd_last_q) begin
            state_d = e_acc_seq_idle;
          end else begin
            idx_d   = idx_q + len_width_p'(1);
            state_d = e_acc_seq_act;
          end
        end
      end
      default: state_d = e_acc_seq_idle;
    endcase

    len_d       = len_width_p'(desc_d.len);
    dest_v_d    = (state_d == e_acc_seq_dest);
    cmd_v_d     = (state_d == e_acc_seq_act) | (state_d == e_acc_seq_wt);
    cmd_act_d   = (state_d == e_acc_seq_act);
    dest_addr_d = paddr_width_p'(desc_d.dest);
    base_d      = cmd_act_d ? paddr_width_p'(desc_d.act_base) : paddr_width_p'(desc_d.wt_base);
    cmd_addr_d  = base_d + (paddr_width_p'(idx_d) << blk_shift_lp);
    cmd_last_d  = (idx_d == len_d - len_width_p'(1));
    err_d       = zero_len | ack_underflow;
    done_d      = wb_ack_i & ~ack_underflow;
    cfg_ready_d = (state_d == e_acc_seq_idle) & (credit_cnt_next < cnt_width_lp'(credits_p));
    busy_d      = (state_d != e_acc_seq_idle) | (credit_cnt_next != '0);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_acc_seq_idle;
      desc_q      <= '0;
      idx_q       <= '0;
      cfg_ready_q <= 1'b1;
      dest_v_q    <= 1'b0;
      dest_addr_q <= '0;
      cmd_v_q     <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_act_q   <= 1'b0;
      cmd_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      desc_q      <= desc_d;
      idx_q       <= idx_d;
      cfg_ready_q <= cfg_ready_d;
      dest_v_q    <= dest_v_d;
      dest_addr_q <= dest_addr_d;
      cmd_v_q     <= cmd_v_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_act_q   <= cmd_act_d;
      cmd_last_q  <= cmd_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign cfg_ready_o      = cfg_ready_q;
  assign dest_v_o         = dest_v_q;
  assign dest_addr_o      = dest_addr_q;
  assign cmd_v_o          = cmd_v_q;
  assign cmd_addr_o       = cmd_addr_q;
  assign cmd_act_not_wt_o = cmd_act_q;
  assign cmd_last_o       = cmd_last_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_bp_be_acc_tile_sequencer.sv
// Bench for the tile sequencer: expected dest/cmd stream queued on descriptor send,
// checked at each observed handshake, plus per-scenario control-signal checks.
module tb_bp_be_acc_tile_sequencer;

  localparam int AW = 40;
  localparam int LW = 16;
  localparam int W  = 43;

  logic          clk, rst_n;
  logic          cfg_v, cfg_ready_o;
  logic [AW-1:0] cfg_act, cfg_wt, cfg_dest;
  logic [LW-1:0] cfg_len;
  logic          dest_v_o, dest_ready;
  logic [AW-1:0] dest_addr_o;
  logic          cmd_v_o, cmd_act_not_wt_o, cmd_last_o, cmd_ready;
  logic [AW-1:0] cmd_addr_o;
  logic          wb_ack, done_o, err_o, busy_o;

  logic [W-1:0] exp_q[$];
  int           hs_q[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           valid_seen = 0;

  bp_be_acc_tile_sequencer dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .cfg_v_i          (cfg_v),
    .cfg_ready_o      (cfg_ready_o),
    .cfg_act_base_i   (cfg_act),
    .cfg_wt_base_i    (cfg_wt),
    .cfg_dest_i       (cfg_dest),
    .cfg_len_i        (cfg_len),
    .dest_v_o         (dest_v_o),
    .dest_addr_o      (dest_addr_o),
    .dest_ready_i     (dest_ready),
    .cmd_v_o          (cmd_v_o),
    .cmd_addr_o       (cmd_addr_o),
    .cmd_act_not_wt_o (cmd_act_not_wt_o),
    .cmd_last_o       (cmd_last_o),
    .cmd_ready_i      (cmd_ready),
    .wb_ack_i         (wb_ack),
    .done_o           (done_o),
    .err_o            (err_o),
    .busy_o           (busy_o)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] enc(input logic [1:0] kind, input logic last, input logic [AW-1:0] addr);
    return {kind, last, addr};
  endfunction

  task automatic push_tile(input logic [AW-1:0] act, input logic [AW-1:0] wt,
                           input logic [AW-1:0] dest, input int len);
    logic [AW-1:0] off;
    exp_q.push_back(enc(2'b10, 1'b0, dest));
    for (int i = 0; i < len; i++) begin
      off = AW'(i * 64);
      exp_q.push_back(enc(2'b01, (i == len - 1), act + off));
      exp_q.push_back(enc(2'b00, (i == len - 1), wt + off));
    end
  endtask

  // Drivers: inputs change 1 time unit after the rising edge.
  task automatic send_desc(input logic [AW-1:0] act, input logic [AW-1:0] wt,
                           input logic [AW-1:0] dest, input int len, output int acc_cyc);
    logic got;
    got = 1'b0;
    acc_cyc = -1;
    @(posedge clk); #1;
    cfg_act = act; cfg_wt = wt; cfg_dest = dest; cfg_len = LW'(len); cfg_v = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (cfg_ready_o) got = 1'b1;
    end
    if (got && len != 0) push_tile(act, wt, dest, len);
    @(posedge clk); #1;
    acc_cyc = cyc;
    cfg_v = 1'b0;
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL cfg_accept: cfg_ready_o got 0 expected 1 within 200 cycles");
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int t = 0; t < budget && exp_q.size() != 0; t++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d items left expected 0", exp_q.size());
    end
  endtask

  task automatic ack_pulse();
    @(posedge clk); #1; wb_ack = 1'b1;
    @(posedge clk); #1; wb_ack = 1'b0;
  endtask

  // Scoreboard monitor: handshakes, one-hot valids and hold-under-stall.
  logic          prev_cv, prev_dv;
  logic [AW+2:0] prev_cmd;
  logic [AW:0]   prev_dst;
  initial begin
    logic [W-1:0] obs, exp;
    logic         hs;
    prev_cv = 1'b0; prev_dv = 1'b0; prev_cmd = '0; prev_dst = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cv = 1'b0; prev_dv = 1'b0;
      end else begin
        if (dest_v_o || cmd_v_o) begin
          valid_seen++;
          n_cmp++;
          if (dest_v_o && cmd_v_o) begin
            n_fail++;
            $display("FAIL one_valid: dest_v_o=1 cmd_v_o=1 expected at most one");
          end
        end
        if (prev_cv) begin
          n_cmp++;
          if ({cmd_v_o, cmd_addr_o, cmd_act_not_wt_o, cmd_last_o} !== prev_cmd) begin
            n_fail++;
            $display("FAIL cmd_hold: got %h expected %h", {cmd_v_o, cmd_addr_o, cmd_act_not_wt_o, cmd_last_o}, prev_cmd);
          end
        end
        if (prev_dv) begin
          n_cmp++;
          if ({dest_v_o, dest_addr_o} !== prev_dst) begin
            n_fail++;
            $display("FAIL dest_hold: got %h expected %h", {dest_v_o, dest_addr_o}, prev_dst);
          end
        end
        hs = 1'b0;
        obs = '0;
        if (dest_v_o && dest_ready) begin
          hs = 1'b1; obs = enc(2'b10, 1'b0, dest_addr_o);
        end else if (cmd_v_o && cmd_ready) begin
          hs = 1'b1; obs = enc({1'b0, cmd_act_not_wt_o}, cmd_last_o, cmd_addr_o);
        end
        if (hs) begin
          hs_q.push_back(cyc);
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL stream: got %h expected nothing", obs);
          end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
              n_fail++;
              $display("FAIL stream: got %h expected %h", obs, exp);
            end
          end
        end
        prev_cv  = cmd_v_o && !cmd_ready;
        prev_cmd = {cmd_v_o, cmd_addr_o, cmd_act_not_wt_o, cmd_last_o};
        prev_dv  = dest_v_o && !dest_ready;
        prev_dst = {dest_v_o, dest_addr_o};
      end
    end
  end

  task automatic test_reset();
    logic [AW*2+7:0] got_v, exp_v;
    #12;
    got_v = {cfg_ready_o, dest_v_o, dest_addr_o, cmd_v_o, cmd_addr_o, cmd_act_not_wt_o, cmd_last_o, done_o, err_o, busy_o};
    exp_v = '0;
    exp_v[AW*2+7] = 1'b1;
    n_cmp++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_vals: got %h expected %h", got_v, exp_v);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cfg_ready_o, busy_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset: cfg_ready/busy got %b expected 10", {cfg_ready_o, busy_o});
    end
  endtask

  task automatic test_basic();
    int acc;
    dest_ready = 1'b1; cmd_ready = 1'b1;
    hs_q.delete();
    send_desc(40'h1000, 40'h2000, 40'h8000, 3, acc);
    wait_drain(50);
    // acc is the cycle right after the accepting edge, i.e. the dest cycle.
    n_cmp++;
    if (hs_q.size() != 7 || hs_q[0] != acc || hs_q[6] != acc + 6) begin
      n_fail++;
      $display("FAIL basic_timing: got n=%0d first=%0d last=%0d expected n=7 first=%0d last=%0d",
               hs_q.size(), (hs_q.size() > 0) ? hs_q[0] : -1, (hs_q.size() > 6) ? hs_q[6] : -1, acc, acc + 6);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({busy_o, done_o} !== 2'b10) begin
        n_fail++;
        $display("FAIL basic_busy: busy/done got %b expected 10", {busy_o, done_o});
      end
    end
    ack_pulse();
    @(negedge clk);
    n_cmp++;
    if ({done_o, err_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_done: done/err got %b expected 10", {done_o, err_o});
    end
    @(negedge clk);
    n_cmp++;
    if ({done_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_idle: done/busy got %b expected 00", {done_o, busy_o});
    end
  endtask

  task automatic test_stall();
    int acc;
    dest_ready = 1'b0; cmd_ready = 1'b0;
    send_desc(40'h1000, 40'h2000, 40'h8000, 3, acc);
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) begin
      @(posedge clk); #1;
      dest_ready = 1'($urandom_range(0, 1));
      cmd_ready  = 1'($urandom_range(0, 1));
    end
    wait_drain(10);
    dest_ready = 1'b1; cmd_ready = 1'b1;
    ack_pulse();
    @(negedge clk);
    n_cmp++;
    if ({done_o, busy_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL stall_done: done/busy got %b expected 10", {done_o, busy_o});
    end
  endtask

  task automatic test_credits();
    int acc;
    dest_ready = 1'b1; cmd_ready = 1'b1;
    send_desc(40'h1100, 40'h2100, 40'h8100, 1, acc);
    send_desc(40'h1200, 40'h2200, 40'h8200, 1, acc);
    @(posedge clk); #1;
    cfg_act = 40'h1300; cfg_wt = 40'h2300; cfg_dest = 40'h8300; cfg_len = 16'd2; cfg_v = 1'b1;
    wait_drain(50);
    push_tile(40'h1300, 40'h2300, 40'h8300, 2);
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if ({cfg_ready_o, dest_v_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL credit_block: cfg_ready/dest_v got %b expected 00", {cfg_ready_o, dest_v_o});
      end
    end
    ack_pulse();
    @(negedge clk);
    n_cmp++;
    if ({cfg_ready_o, done_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL credit_restore: cfg_ready/done got %b expected 11", {cfg_ready_o, done_o});
    end
    @(posedge clk); #1; cfg_v = 1'b0;
    wait_drain(50);
    repeat (2) begin
      ack_pulse();
      @(negedge clk);
      n_cmp++;
      if (done_o !== 1'b1) begin
        n_fail++;
        $display("FAIL credit_ack: done_o got %b expected 1", done_o);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_idle: busy_o got %b expected 0", busy_o);
    end
  endtask

  task automatic test_zero_len();
    int acc, v0;
    v0 = valid_seen;
    send_desc(40'h1000, 40'h2000, 40'h8000, 0, acc);
    @(negedge clk);
    n_cmp++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_err: err_o got %b expected 1", err_o);
    end
    @(negedge clk);
    n_cmp++;
    if ({err_o, cfg_ready_o, busy_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL zero_after: err/cfg_ready/busy got %b expected 010", {err_o, cfg_ready_o, busy_o});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (valid_seen != v0) begin
      n_fail++;
      $display("FAIL zero_quiet: valid cycles got %0d expected %0d", valid_seen, v0);
    end
  endtask

  task automatic test_spurious_ack();
    ack_pulse();
    @(negedge clk);
    n_cmp++;
    if ({err_o, done_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL spur_err: err/done got %b expected 10", {err_o, done_o});
    end
    @(negedge clk);
    n_cmp++;
    if ({err_o, busy_o, cfg_ready_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL spur_after: err/busy/cfg_ready got %b expected 001", {err_o, busy_o, cfg_ready_o});
    end
  endtask

  task automatic test_wrap();
    int acc;
    send_desc(40'hFF_FFFF_FFC0, 40'h3000, 40'h9000, 2, acc);
    wait_drain(50);
    ack_pulse();
    @(negedge clk);
    n_cmp++;
    if ({done_o, err_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL wrap_done: done/err got %b expected 10", {done_o, err_o});
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    send_desc(40'h4000, 40'h5000, 40'hA000, 2, acc);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if ({cmd_v_o, cmd_act_not_wt_o, cmd_last_o, cmd_addr_o} !== {3'b101, 40'h5040}) begin
      n_fail++;
      $display("FAIL mid_pre: got %h expected %h", {cmd_v_o, cmd_act_not_wt_o, cmd_last_o, cmd_addr_o}, {3'b101, 40'h5040});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dest_v_o, cmd_v_o, done_o, err_o, busy_o, cfg_ready_o} !== 6'b000001) begin
      n_fail++;
      $display("FAIL mid_async: got %b expected 000001", {dest_v_o, cmd_v_o, done_o, err_o, busy_o, cfg_ready_o});
    end
    exp_q.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cfg_ready_o, busy_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_release: cfg_ready/busy got %b expected 10", {cfg_ready_o, busy_o});
    end
    ack_pulse();
    @(negedge clk);
    n_cmp++;
    if ({err_o, done_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_stale_ack: err/done got %b expected 10", {err_o, done_o});
    end
    send_desc(40'h6000, 40'h7000, 40'hB000, 1, acc);
    wait_drain(50);
    ack_pulse();
    @(negedge clk);
    n_cmp++;
    if ({done_o, err_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_new_tile: done/err got %b expected 10", {done_o, err_o});
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_v = 1'b0; cfg_act = '0; cfg_wt = '0; cfg_dest = '0; cfg_len = '0;
    dest_ready = 1'b0; cmd_ready = 1'b0; wb_ack = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_credits();
    test_zero_len();
    test_spurious_ack();
    test_wrap();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: %0d items left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
